// File: rtl/fsm_proc_pkg.sv
// Shared types and constants for the processor phase sequencer.
// Also holds the helper that sizes the phase index.
package fsm_proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } top_state_t;

    // Phase names of the original fixed 4-phase controller
    localparam int FETCH  = 0;
    localparam int DECODE = 1;
    localparam int EXEC   = 2;
    localparam int WRITE  = 3;

    function automatic int phase_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the instruction decoder, the phase sequencer
// and the datapath.
interface phase_sequencer_if
    import fsm_proc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16
) ();
    localparam int PHASE_W = phase_width(NUM_PHASES);

    logic                  run;
    logic                  halt;
    logic                  stall;
    logic                  jump_req;
    logic [PHASE_W-1:0]    jump_phase;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic [PHASE_W-1:0]    phase_idx;
    logic                  busy;
    logic                  cycle_done;
    logic [CNT_W-1:0]      cycle_count;
    logic                  jump_err;

    modport master (
        output run, halt, stall, jump_req, jump_phase,
        input  phase_onehot, phase_idx, busy, cycle_done, cycle_count, jump_err
    );

    modport slave (
        input  run, halt, stall, jump_req, jump_phase,
        output phase_onehot, phase_idx, busy, cycle_done, cycle_count, jump_err
    );
endinterface

// File: rtl/phase_decoder.sv
// Binary phase index to one-hot enable vector, gated by an enable.
// The datapath also reuses this for its mux selects.
module phase_decoder #(
    parameter int NUM_PHASES = 4,
    parameter int PHASE_W    = 2
) (
    input  logic [PHASE_W-1:0]    idx,
    input  logic                  en,
    output logic [NUM_PHASES-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            onehot[i] = en && (idx == PHASE_W'(i));
        end
    end
endmodule

// File: rtl/phase_sequencer.sv
// Steps the processor through NUM_PHASES execution phases with run/halt,
// stall, runtime jump, completed-cycle pulse and cycle counter.
module phase_sequencer
    import fsm_proc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16,
    parameter bit AUTO_START = 1'b1
) (
    input  logic clk,
    input  logic rst,
    phase_sequencer_if.slave sif
);
    localparam int PHASE_W = phase_width(NUM_PHASES);
    localparam top_state_t RESET_STATE = AUTO_START ? RUN : IDLE;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    top_state_t         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               halt_pend_q, halt_pend_d;
    logic               cycle_done_q, cycle_done_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               jump_err_q, jump_err_d;

    logic [PHASE_W-1:0] next_phase;
    logic               jump_ok;
    logic               in_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RESET_STATE;
            phase_q       <= '0;
            halt_pend_q   <= 1'b0;
            cycle_done_q  <= 1'b0;
            cycle_count_q <= '0;
            jump_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            halt_pend_q   <= halt_pend_d;
            cycle_done_q  <= cycle_done_d;
            cycle_count_q <= cycle_count_d;
            jump_err_q    <= jump_err_d;
        end
    end

    // Widened compare so NUM_PHASES itself fits when it is a power of two
    assign jump_ok = ({1'b0, sif.jump_phase} < (PHASE_W + 1)'(NUM_PHASES));

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        halt_pend_d   = halt_pend_q;
        cycle_done_d  = 1'b0;
        cycle_count_d = cycle_count_q;
        jump_err_d    = jump_err_q;
        next_phase    = phase_q;

        unique case (state_q)
            RUN: begin
                if (sif.halt) begin
                    halt_pend_d = 1'b1;
                end
                if (!sif.stall) begin
                    if (sif.jump_req && jump_ok) begin
                        next_phase = sif.jump_phase;
                    end else begin
                        if (sif.jump_req) begin
                            jump_err_d = 1'b1;
                        end
                        next_phase = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
                    end
                    phase_d = next_phase;
                    // Instruction-cycle boundary: count it, and honour any halt request
                    if (next_phase == '0) begin
                        cycle_done_d  = 1'b1;
                        cycle_count_d = cycle_count_q + 1'b1;
                        if (halt_pend_q || sif.halt) begin
                            state_d     = HALTED;
                            halt_pend_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                halt_pend_d = 1'b0;
                phase_d     = '0;
                if (sif.run && !sif.halt) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    assign in_run = (state_q == RUN);

    phase_decoder #(
        .NUM_PHASES (NUM_PHASES),
        .PHASE_W    (PHASE_W)
    ) u_phase_decoder (
        .idx    (phase_q),
        .en     (in_run),
        .onehot (sif.phase_onehot)
    );

    assign sif.phase_idx   = in_run ? phase_q : '0;
    assign sif.busy        = in_run;
    assign sif.cycle_done  = cycle_done_q;
    assign sif.cycle_count = cycle_count_q;
    assign sif.jump_err    = jump_err_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a 4-phase auto-start instance and a
// 5-phase instance that waits for run out of reset.
module tb_phase_sequencer;
    import fsm_proc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_sequencer_if #(.NUM_PHASES(4), .CNT_W(16)) a_if ();
    phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(8))  b_if ();

    phase_sequencer #(.NUM_PHASES(4), .CNT_W(16), .AUTO_START(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .sif (a_if.slave)
    );

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(8), .AUTO_START(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .sif (b_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int skip_exp[6] = '{2, 3, 0, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int idx, input bit done);
        chk({tag, ".idx"},  32'(a_if.phase_idx),  32'(idx));
        chk({tag, ".done"}, 32'(a_if.cycle_done), 32'(done));
    endtask

    task automatic chk_b(input string tag, input int idx, input bit done);
        chk({tag, ".idx"},  32'(b_if.phase_idx),  32'(idx));
        chk({tag, ".done"}, 32'(b_if.cycle_done), 32'(done));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.run = 1'b0; a_if.halt = 1'b0; a_if.stall = 1'b0;
        a_if.jump_req = 1'b0; a_if.jump_phase = '0;
        b_if.run = 1'b0; b_if.halt = 1'b0; b_if.stall = 1'b0;
        b_if.jump_req = 1'b0; b_if.jump_phase = '0;
        rst = 1'b1;
        #2;
        chk("rst_a.onehot", 32'(a_if.phase_onehot), 32'h1);
        chk("rst_a.busy",   32'(a_if.busy),         32'h1);
        chk("rst_a.count",  32'(a_if.cycle_count),  32'h0);
        chk("rst_a.done",   32'(a_if.cycle_done),   32'h0);
        chk("rst_b.onehot", 32'(b_if.phase_onehot), 32'h0);
        chk("rst_b.busy",   32'(b_if.busy),         32'h0);
        #1 rst = 1'b0;

        // Free-running sequence
        chk_a("run0", 0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_a("run", k % 4, (k % 4) == 0);
            if (k == 2) chk("run.onehot", 32'(a_if.phase_onehot), 32'h4);
        end
        chk("run.count", 32'(a_if.cycle_count), 32'd3);

        // Legacy conditional skip of phase 1
        for (int k = 0; k < 6; k++) begin
            a_if.jump_req   = (a_if.phase_idx == FETCH[1:0]);
            a_if.jump_phase = EXEC[1:0];
            tick();
            chk_a("skip", skip_exp[k], skip_exp[k] == 0);
        end
        a_if.jump_req = 1'b0;
        chk("skip.count", 32'(a_if.cycle_count), 32'd5);

        // Stall beats a jump to phase 0
        tick();
        chk_a("pre_stall", 1, 1'b0);
        a_if.stall = 1'b1; a_if.jump_req = 1'b1; a_if.jump_phase = FETCH[1:0];
        repeat (5) begin
            tick();
            chk_a("stall", 1, 1'b0);
        end
        chk("stall.count", 32'(a_if.cycle_count), 32'd5);
        a_if.stall = 1'b0; a_if.jump_req = 1'b0;
        tick(); chk_a("resume", 2, 1'b0);
        tick(); chk_a("resume", 3, 1'b0);
        tick(); chk_a("resume", 0, 1'b1);
        chk("resume.count", 32'(a_if.cycle_count), 32'd6);

        // Halt pulse in phase 1 stops at the next boundary
        tick(); chk_a("pre_halt", 1, 1'b0);
        a_if.halt = 1'b1;
        tick(); chk_a("halt", 2, 1'b0);
        a_if.halt = 1'b0;
        tick(); chk_a("halt", 3, 1'b0);
        chk("halt.busy3", 32'(a_if.busy), 32'h1);
        tick();
        chk_a("halted", 0, 1'b1);
        chk("halted.busy",   32'(a_if.busy),         32'h0);
        chk("halted.onehot", 32'(a_if.phase_onehot), 32'h0);
        chk("halted.count",  32'(a_if.cycle_count),  32'd7);
        tick();
        chk("halted2.busy", 32'(a_if.busy),       32'h0);
        chk("halted2.done", 32'(a_if.cycle_done), 32'h0);
        a_if.run = 1'b1;
        tick();
        chk_a("rerun", 0, 1'b0);
        chk("rerun.busy",   32'(a_if.busy),         32'h1);
        chk("rerun.onehot", 32'(a_if.phase_onehot), 32'h1);
        chk("rerun.count",  32'(a_if.cycle_count),  32'd7);
        a_if.run = 1'b0;
        tick(); chk_a("rerun", 1, 1'b0);

        // 5-phase instance: start from IDLE, out-of-range and in-range jumps
        chk("b_idle.busy", 32'(b_if.busy), 32'h0);
        b_if.run = 1'b1;
        tick();
        chk_b("b_start", 0, 1'b0);
        chk("b_start.busy", 32'(b_if.busy), 32'h1);
        b_if.run = 1'b0;
        tick(); chk_b("b_run", 1, 1'b0);
        b_if.jump_req = 1'b1; b_if.jump_phase = 3'd6;
        tick(); chk_b("b_badjump", 2, 1'b0);
        chk("b_badjump.err", 32'(b_if.jump_err), 32'h1);
        b_if.jump_req = 1'b0;
        tick(); chk_b("b_run", 3, 1'b0);
        chk("b_sticky.err", 32'(b_if.jump_err), 32'h1);
        tick(); chk_b("b_run", 4, 1'b0);
        tick(); chk_b("b_wrap", 0, 1'b1);
        chk("b_wrap.count", 32'(b_if.cycle_count), 32'd1);
        b_if.jump_req = 1'b1; b_if.jump_phase = 3'd4;
        tick(); chk_b("b_jump4", 4, 1'b0);
        b_if.jump_req = 1'b0;
        tick(); chk_b("b_wrap2", 0, 1'b1);
        chk("b_wrap2.count", 32'(b_if.cycle_count), 32'd2);
        tick(); chk_b("b_run", 1, 1'b0);
        b_if.halt = 1'b1;
        tick(); chk_b("b_halt", 2, 1'b0);
        b_if.halt = 1'b0;

        // Asynchronous reset in the middle of phase 2 with a halt pending
        #2 rst = 1'b1;
        #1;
        chk("arst_b.busy",   32'(b_if.busy),         32'h0);
        chk("arst_b.onehot", 32'(b_if.phase_onehot), 32'h0);
        chk("arst_b.idx",    32'(b_if.phase_idx),    32'h0);
        chk("arst_b.err",    32'(b_if.jump_err),     32'h0);
        chk("arst_b.count",  32'(b_if.cycle_count),  32'h0);
        chk("arst_a.onehot", 32'(a_if.phase_onehot), 32'h1);
        rst = 1'b0;
        b_if.run = 1'b1; b_if.halt = 1'b1;
        tick();
        chk("b_runhalt.busy", 32'(b_if.busy), 32'h0);
        b_if.halt = 1'b0;
        tick();
        chk_b("b_restart", 0, 1'b0);
        chk("b_restart.busy", 32'(b_if.busy), 32'h1);
        b_if.run = 1'b0;
        repeat (5) tick();
        chk_b("b_nohalt", 0, 1'b1);
        chk("b_nohalt.busy", 32'(b_if.busy), 32'h1);
        tick(); chk_b("b_nohalt", 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
